// File: rtl/mbox_wr_arbiter.sv
// Round-robin arbiter that serialises NREQ 32-bit requester words, MSB byte first, onto the byte-wide mailbox write port.
// Optional macro MBOX_ARB_HDR_EN inserts a header byte {4'hA,1'b0,winner[2:0]} ahead of each word.
module mbox_wr_arbiter #(
    parameter int NREQ   = 2,
    parameter int WB_DW  = 32,
    parameter int WOU_DW = 8
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_i,
    input  logic [NREQ-1:0]        req_i,
    input  logic [NREQ*WB_DW-1:0]  dat_i,
    output logic [NREQ-1:0]        ack_o,
    output logic [NREQ-1:0]        grant_o,
    output logic                   busy_o,
    output logic                   mbox_wr_o,
    output logic [WOU_DW-1:0]      mbox_do_o,
    input  logic                   mbox_full_i
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

`ifdef MBOX_ARB_HDR_EN
    typedef enum logic [1:0] { IDLE = 2'd0, SEND = 2'd1, HDR = 2'd2 } state_t;
`else
    typedef enum logic [1:0] { IDLE = 2'd0, SEND = 2'd1 } state_t;
`endif

    state_t             state_q, state_d;
    logic [1:0]         cnt_q, cnt_d;
    logic [WB_DW-1:0]   buf_q, buf_d;
    logic [PW-1:0]      ptr_q, ptr_d;
    logic [NREQ-1:0]    ack_q, ack_d;
    logic [NREQ-1:0]    grant_q, grant_d;

    logic               hi_found_s, lo_found_s, any_s;
    logic [PW-1:0]      hi_win_s, lo_win_s, win_s;
    logic [NREQ-1:0]    onehot_s;
    logic [WB_DW-1:0]   word_s;
    logic               wr_s;
    logic [WOU_DW-1:0]  do_s;

    // Round-robin search: lowest requester above the pointer wins, else wrap to the lowest at or below it.
    always_comb begin
        hi_found_s = 1'b0;
        lo_found_s = 1'b0;
        hi_win_s   = '0;
        lo_win_s   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (req_i[k] && !hi_found_s && (PW'(k) > ptr_q)) begin
                hi_found_s = 1'b1;
                hi_win_s   = PW'(k);
            end else if (req_i[k] && !lo_found_s && (PW'(k) <= ptr_q)) begin
                lo_found_s = 1'b1;
                lo_win_s   = PW'(k);
            end else begin
            end
        end
        any_s = hi_found_s | lo_found_s;
        win_s = hi_found_s ? hi_win_s : lo_win_s;
    end

    // Winner decode: one-hot grant vector and the selected requester word.
    always_comb begin
        onehot_s = '0;
        word_s   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (PW'(k) == win_s) begin
                onehot_s[k] = 1'b1;
                word_s      = dat_i[k*WB_DW +: WB_DW];
            end else begin
            end
        end
    end

    // Transfer FSM next state, mailbox strobe and data.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        ptr_d   = ptr_q;
        ack_d   = '0;
        grant_d = grant_q;
        wr_s    = 1'b0;
        do_s    = buf_q[WB_DW-1 -: WOU_DW];
        case (state_q)
            IDLE: begin
                if (any_s) begin
                    buf_d   = word_s;
                    ack_d   = onehot_s;
                    grant_d = onehot_s;
                    ptr_d   = win_s;
                    cnt_d   = 2'd0;
`ifdef MBOX_ARB_HDR_EN
                    state_d = HDR;
`else
                    state_d = SEND;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
`ifdef MBOX_ARB_HDR_EN
            HDR: begin
                wr_s = ~mbox_full_i;
                do_s = {4'hA, 1'b0, 3'(ptr_q)};
                if (wr_s) begin
                    state_d = SEND;
                end else begin
                    state_d = HDR;
                end
            end
`endif
            SEND: begin
                wr_s = ~mbox_full_i;
                if (wr_s) begin
                    buf_d = {buf_q[WB_DW-WOU_DW-1:0], {WOU_DW{1'b0}}};
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_d = IDLE;
                        grant_d = '0;
                    end else begin
                        state_d = SEND;
                    end
                end else begin
                    state_d = SEND;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    // State, buffer, pointer and handshake registers.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
            buf_q   <= '0;
            ptr_q   <= PW'(NREQ - 1);
            ack_q   <= '0;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
            ptr_q   <= ptr_d;
            ack_q   <= ack_d;
            grant_q <= grant_d;
        end
    end

    assign ack_o     = ack_q;
    assign grant_o   = grant_q;
    assign busy_o    = (state_q != IDLE);
    assign mbox_wr_o = wr_s;
    assign mbox_do_o = do_s;

endmodule

// File: tb/tb_mbox_wr_arbiter.sv
// Directed bench for mbox_wr_arbiter: cycle tables for the default build plus a byte-collecting sequence with backpressure.
module tb_mbox_wr_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req;
    logic [63:0] dat;
    logic [1:0]  ack, grant;
    logic        busy, wr, full;
    logic [7:0]  dout;

    always #5 clk = ~clk;

    mbox_wr_arbiter #(.NREQ(2), .WB_DW(32), .WOU_DW(8)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .req_i(req), .dat_i(dat),
        .ack_o(ack), .grant_o(grant), .busy_o(busy),
        .mbox_wr_o(wr), .mbox_do_o(dout), .mbox_full_i(full)
    );

    typedef struct {
        logic        r;
        logic [1:0]  q;
        logic        f;
        logic [31:0] d0, d1;
        logic [1:0]  ea, eg;
        logic        eb, ew;
        logic [7:0]  ed;
    } vec_t;

    vec_t tbl[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    localparam logic [31:0] W = 32'h11223344;
    localparam logic [31:0] A = 32'hA0A1A2A3;
    localparam logic [31:0] B = 32'hB0B1B2B3;

    task automatic add(input logic r, input logic [1:0] q, input logic f,
                       input logic [31:0] d0, input logic [31:0] d1,
                       input logic [1:0] ea, input logic [1:0] eg,
                       input logic eb, input logic ew, input logic [7:0] ed);
        vec_t v;
        v.r = r; v.q = q; v.f = f; v.d0 = d0; v.d1 = d1;
        v.ea = ea; v.eg = eg; v.eb = eb; v.ew = ew; v.ed = ed;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_table();
        foreach (tbl[i]) begin
            @(negedge clk);
            rst  = tbl[i].r;
            req  = tbl[i].q;
            full = tbl[i].f;
            dat  = {tbl[i].d1, tbl[i].d0};
            #1;
            n_chk++;
            if ({ack, grant, busy, wr, dout} !== {tbl[i].ea, tbl[i].eg, tbl[i].eb, tbl[i].ew, tbl[i].ed}) begin
                n_fail++;
                $display("FAIL vec%0d: got ack=%b grant=%b busy=%b wr=%b do=%h expected ack=%b grant=%b busy=%b wr=%b do=%h",
                         i, ack, grant, busy, wr, dout,
                         tbl[i].ea, tbl[i].eg, tbl[i].eb, tbl[i].ew, tbl[i].ed);
            end
        end
    endtask

    // Requester 1 sends DEADBEEF while the mailbox is full every third cycle; bytes are collected from strobes.
    task automatic run_collect();
        logic [7:0] got[$];
        logic [7:0] exp_b[$];
        int  acks    = 0;
        int  bad_ack = 0;
        bit  done    = 1'b0;
`ifdef MBOX_ARB_HDR_EN
        exp_b.push_back(8'hA1);
`endif
        exp_b.push_back(8'hDE); exp_b.push_back(8'hAD);
        exp_b.push_back(8'hBE); exp_b.push_back(8'hEF);
        @(negedge clk);
        rst = 1'b1; req = 2'b00; full = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        dat = {32'hDEADBEEF, 32'h01020304};
        req = 2'b10;
        for (int c = 0; c < 60 && !done; c++) begin
            if (c > 0) @(negedge clk);
            full = ((c % 3) == 2);
            #1;
            if (wr) got.push_back(dout);
            if (ack == 2'b10) begin
                acks++;
                req = 2'b00;
            end else if (ack != 2'b00) begin
                bad_ack++;
            end
            if (got.size() >= exp_b.size() && !busy) done = 1'b1;
        end
        full = 1'b0;
        chk("collect_done", {31'd0, done}, 32'd1);
        chk("collect_count", got.size(), exp_b.size());
        chk("collect_acks", acks, 32'd1);
        chk("collect_bad_ack", bad_ack, 32'd0);
        foreach (exp_b[i]) begin
            if (i < got.size()) chk($sformatf("collect_byte%0d", i), {24'd0, got[i]}, {24'd0, exp_b[i]});
            else chk($sformatf("collect_byte%0d_missing", i), 32'd0, 32'd1);
        end
    endtask

    initial begin
        rst = 1'b1; req = 2'b00; full = 1'b0; dat = 64'd0;

`ifndef MBOX_ARB_HDR_EN
        // Single word from requester 0.
        add(1'b1, 2'b00, 1'b0, W, 32'd0, 2'b00, 2'b00, 1'b0, 1'b0, 8'h00);
        add(1'b0, 2'b01, 1'b0, W, 32'd0, 2'b00, 2'b00, 1'b0, 1'b0, 8'h00);
        add(1'b0, 2'b00, 1'b0, W, 32'd0, 2'b01, 2'b01, 1'b1, 1'b1, 8'h11);
        add(1'b0, 2'b00, 1'b0, W, 32'd0, 2'b00, 2'b01, 1'b1, 1'b1, 8'h22);
        add(1'b0, 2'b00, 1'b0, W, 32'd0, 2'b00, 2'b01, 1'b1, 1'b1, 8'h33);
        add(1'b0, 2'b00, 1'b0, W, 32'd0, 2'b00, 2'b01, 1'b1, 1'b1, 8'h44);
        add(1'b0, 2'b00, 1'b0, W, 32'd0, 2'b00, 2'b00, 1'b0, 1'b0, 8'h00);
        // Both requesting continuously: A, B, A with an idle cycle between words.
        add(1'b1, 2'b00, 1'b0, A, B, 2'b00, 2'b00, 1'b0, 1'b0, 8'h00);
        add(1'b0, 2'b11, 1'b0, A, B, 2'b00, 2'b00, 1'b0, 1'b0, 8'h00);
        add(1'b0, 2'b11, 1'b0, A, B, 2'b01, 2'b01, 1'b1, 1'b1, 8'hA0);
        add(1'b0, 2'b11, 1'b0, A, B, 2'b00, 2'b01, 1'b1, 1'b1, 8'hA1);
        add(1'b0, 2'b11, 1'b0, A, B, 2'b00, 2'b01, 1'b1, 1'b1, 8'hA2);
        add(1'b0, 2'b11, 1'b0, A, B, 2'b00, 2'b01, 1'b1, 1'b1, 8'hA3);
        add(1'b0, 2'b11, 1'b0, A, B, 2'b00, 2'b00, 1'b0, 1'b0, 8'h00);
        add(1'b0, 2'b11, 1'b0, A, B, 2'b10, 2'b10, 1'b1, 1'b1, 8'hB0);
        add(1'b0, 2'b11, 1'b0, A, B, 2'b00, 2'b10, 1'b1, 1'b1, 8'hB1);
        add(1'b0, 2'b11, 1'b0, A, B, 2'b00, 2'b10, 1'b1, 1'b1, 8'hB2);
        add(1'b0, 2'b11, 1'b0, A, B, 2'b00, 2'b10, 1'b1, 1'b1, 8'hB3);
        add(1'b0, 2'b11, 1'b0, A, B, 2'b00, 2'b00, 1'b0, 1'b0, 8'h00);
        add(1'b0, 2'b11, 1'b0, A, B, 2'b01, 2'b01, 1'b1, 1'b1, 8'hA0);
        // Mailbox full for three cycles after byte 22.
        add(1'b1, 2'b00, 1'b0, W, 32'd0, 2'b00, 2'b00, 1'b0, 1'b0, 8'h00);
        add(1'b0, 2'b01, 1'b0, W, 32'd0, 2'b00, 2'b00, 1'b0, 1'b0, 8'h00);
        add(1'b0, 2'b00, 1'b0, W, 32'd0, 2'b01, 2'b01, 1'b1, 1'b1, 8'h11);
        add(1'b0, 2'b00, 1'b0, W, 32'd0, 2'b00, 2'b01, 1'b1, 1'b1, 8'h22);
        add(1'b0, 2'b00, 1'b1, W, 32'd0, 2'b00, 2'b01, 1'b1, 1'b0, 8'h33);
        add(1'b0, 2'b00, 1'b1, W, 32'd0, 2'b00, 2'b01, 1'b1, 1'b0, 8'h33);
        add(1'b0, 2'b00, 1'b1, W, 32'd0, 2'b00, 2'b01, 1'b1, 1'b0, 8'h33);
        add(1'b0, 2'b00, 1'b0, W, 32'd0, 2'b00, 2'b01, 1'b1, 1'b1, 8'h33);
        add(1'b0, 2'b00, 1'b0, W, 32'd0, 2'b00, 2'b01, 1'b1, 1'b1, 8'h44);
        add(1'b0, 2'b00, 1'b0, W, 32'd0, 2'b00, 2'b00, 1'b0, 1'b0, 8'h00);
        // Reset after the second byte, then requester 0 wins again from the reset pointer.
        add(1'b1, 2'b00, 1'b0, W, B, 2'b00, 2'b00, 1'b0, 1'b0, 8'h00);
        add(1'b0, 2'b01, 1'b0, W, B, 2'b00, 2'b00, 1'b0, 1'b0, 8'h00);
        add(1'b0, 2'b00, 1'b0, W, B, 2'b01, 2'b01, 1'b1, 1'b1, 8'h11);
        add(1'b0, 2'b00, 1'b0, W, B, 2'b00, 2'b01, 1'b1, 1'b1, 8'h22);
        add(1'b1, 2'b11, 1'b0, W, B, 2'b00, 2'b00, 1'b0, 1'b0, 8'h00);
        add(1'b0, 2'b11, 1'b0, W, B, 2'b00, 2'b00, 1'b0, 1'b0, 8'h00);
        add(1'b0, 2'b00, 1'b0, W, B, 2'b01, 2'b01, 1'b1, 1'b1, 8'h11);
        add(1'b0, 2'b00, 1'b0, W, B, 2'b00, 2'b01, 1'b1, 1'b1, 8'h22);
        // Requester 1 pulses for one cycle during a transfer and withdraws.
        add(1'b1, 2'b00, 1'b0, W, B, 2'b00, 2'b00, 1'b0, 1'b0, 8'h00);
        add(1'b0, 2'b01, 1'b0, W, B, 2'b00, 2'b00, 1'b0, 1'b0, 8'h00);
        add(1'b0, 2'b10, 1'b0, W, B, 2'b01, 2'b01, 1'b1, 1'b1, 8'h11);
        add(1'b0, 2'b00, 1'b0, W, B, 2'b00, 2'b01, 1'b1, 1'b1, 8'h22);
        add(1'b0, 2'b00, 1'b0, W, B, 2'b00, 2'b01, 1'b1, 1'b1, 8'h33);
        add(1'b0, 2'b00, 1'b0, W, B, 2'b00, 2'b01, 1'b1, 1'b1, 8'h44);
        add(1'b0, 2'b00, 1'b0, W, B, 2'b00, 2'b00, 1'b0, 1'b0, 8'h00);
        add(1'b0, 2'b00, 1'b0, W, B, 2'b00, 2'b00, 1'b0, 1'b0, 8'h00);
        run_table();
`endif

        run_collect();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
